// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control for the 5-stage Y86 core. Generates the
//               stall/bubble controls for the F, F/D, D/E, E/M and M/W
//               registers from load/use, ret and mispredict hazards,
//               sequences IDLE/RUN/HALTED and keeps bring-up counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned RET_BUBS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       d_icode,
  input  logic [7:0]       d_srcA,
  input  logic [7:0]       d_srcB,
  input  logic [7:0]       ex_icode,
  input  logic [7:0]       ex_dstM,
  input  logic             ex_cnd,
  input  logic [7:0]       w_icode,
  output logic             f_stall,
  output logic             d_stall,
  output logic             d_bubble,
  output logic             e_bubble,
  output logic             m_bubble,
  output logic             w_stall,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bub_cnt
);

  localparam logic [7:0] C_I_HALT   = 8'h00;
  localparam logic [7:0] C_I_JXX    = 8'h07;
  localparam logic [7:0] C_I_RET    = 8'h09;
  localparam logic [7:0] C_I_MRMOVL = 8'h05;
  localparam logic [7:0] C_I_POPL   = 8'h0B;
  localparam logic [7:0] C_R_NONE   = 8'h0F;
  localparam logic [1:0] C_RET_LOAD = 2'(RET_BUBS);
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_running;
  logic       r_halted;
  logic [1:0] r_ret_cnt;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bub_cnt;

  logic w_run;
  logic w_lu;
  logic w_mis;
  logic w_rp;

  assign w_run = (r_state == S_RUN);

  // Load/use: the value a decode source needs is still coming from memory.
  assign w_lu  = ((ex_icode == C_I_MRMOVL) || (ex_icode == C_I_POPL)) &&
                 (ex_dstM != C_R_NONE) &&
                 ((ex_dstM == d_srcA) || (ex_dstM == d_srcB));
  assign w_mis = (ex_icode == C_I_JXX) && !ex_cnd;
  assign w_rp  = (r_ret_cnt != 2'd0);

  // Control outputs: outside RUN the whole pipe is frozen and flushed.
  always_comb begin
    f_stall  = 1'b1;
    d_stall  = 1'b1;
    d_bubble = 1'b0;
    e_bubble = 1'b1;
    m_bubble = 1'b1;
    w_stall  = 1'b1;
    if (w_run) begin
      f_stall  = w_lu | w_rp;
      d_stall  = w_lu;
      d_bubble = !w_lu & (w_mis | w_rp);
      e_bubble = w_lu | w_mis;
      m_bubble = 1'b0;
      w_stall  = 1'b0;
    end
  end

  // Run-state sequencer with registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_icode == C_I_HALT) begin
            r_state   <= S_HALTED;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_halted  <= 1'b0;
        end
      endcase
    end
  end

  // Ret bubble counter; a mispredict means the ret was on the wrong path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ret_cnt <= 2'd0;
    end else if (!w_run) begin
      r_ret_cnt <= 2'd0;
    end else if (w_mis) begin
      r_ret_cnt <= 2'd0;
    end else if (w_rp) begin
      if (!w_lu) begin
        r_ret_cnt <= r_ret_cnt - 2'd1;
      end
    end else if ((d_icode == C_I_RET) && !w_lu) begin
      r_ret_cnt <= C_RET_LOAD;
    end
  end

  // Bring-up counters advance only in RUN and wrap silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt   <= '0;
      r_stall_cnt <= '0;
      r_bub_cnt   <= '0;
    end else if (w_run) begin
      r_cyc_cnt <= r_cyc_cnt + C_CNT_ONE;
      if (d_stall) begin
        r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
      end
      if (d_bubble | e_bubble) begin
        r_bub_cnt <= r_bub_cnt + C_CNT_ONE;
      end
    end
  end

  assign running   = r_running;
  assign halted    = r_halted;
  assign cyc_cnt   = r_cyc_cnt;
  assign stall_cnt = r_stall_cnt;
  assign bub_cnt   = r_bub_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. Expected control vectors
//               and counter values are queued as each cycle is driven and
//               compared once the DUT outputs settle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  d_icode;
  logic [7:0]  d_srcA;
  logic [7:0]  d_srcB;
  logic [7:0]  ex_icode;
  logic [7:0]  ex_dstM;
  logic        ex_cnd;
  logic [7:0]  w_icode;
  logic        f_stall;
  logic        d_stall;
  logic        d_bubble;
  logic        e_bubble;
  logic        m_bubble;
  logic        w_stall;
  logic        running;
  logic        halted;
  logic [31:0] cyc_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] bub_cnt;

  int checks;
  int failures;

  typedef struct {
    string       tag;
    logic [5:0]  ctl;
    logic        run;
    logic        hlt;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] bub;
  } exp_t;

  exp_t sb_q[$];

  // ctl = {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall}
  localparam logic [5:0] C_CTL_IDLE = 6'b110111;
  localparam logic [5:0] C_CTL_NONE = 6'b000000;
  localparam logic [5:0] C_CTL_LU   = 6'b110100;
  localparam logic [5:0] C_CTL_RET  = 6'b101000;
  localparam logic [5:0] C_CTL_MIS  = 6'b001100;
  localparam logic [5:0] C_CTL_RMIS = 6'b101100;

  pipe_ctrl #(.CNT_W(32), .RET_BUBS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .d_icode   (d_icode),
    .d_srcA    (d_srcA),
    .d_srcB    (d_srcB),
    .ex_icode  (ex_icode),
    .ex_dstM   (ex_dstM),
    .ex_cnd    (ex_cnd),
    .w_icode   (w_icode),
    .f_stall   (f_stall),
    .d_stall   (d_stall),
    .d_bubble  (d_bubble),
    .e_bubble  (e_bubble),
    .m_bubble  (m_bubble),
    .w_stall   (w_stall),
    .running   (running),
    .halted    (halted),
    .cyc_cnt   (cyc_cnt),
    .stall_cnt (stall_cnt),
    .bub_cnt   (bub_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [5:0] ctl, input logic run,
                          input logic hlt, input logic [31:0] cyc,
                          input logic [31:0] stl, input logic [31:0] bub);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.run = run; e.hlt = hlt;
    e.cyc = cyc; e.stl = stl; e.bub = bub;
    sb_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    logic [5:0] obs_ctl;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    obs_ctl = {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall};
    chk({e.tag, ".ctl"},   {26'd0, obs_ctl}, {26'd0, e.ctl});
    chk({e.tag, ".run"},   {31'd0, running}, {31'd0, e.run});
    chk({e.tag, ".halt"},  {31'd0, halted},  {31'd0, e.hlt});
    chk({e.tag, ".cyc"},   cyc_cnt,   e.cyc);
    chk({e.tag, ".stall"}, stall_cnt, e.stl);
    chk({e.tag, ".bub"},   bub_cnt,   e.bub);
  endtask

  // One cycle: drive inputs just after posedge, queue expectation, compare at negedge.
  task automatic cyc(input string tag, input logic st, input logic [7:0] di,
                     input logic [7:0] sa, input logic [7:0] sbb,
                     input logic [7:0] ei, input logic [7:0] edm, input logic cnd,
                     input logic [7:0] wi, input logic [5:0] ctl, input logic run,
                     input logic hlt, input logic [31:0] c, input logic [31:0] s,
                     input logic [31:0] b);
    @(posedge clk);
    #1;
    start = st; d_icode = di; d_srcA = sa; d_srcB = sbb;
    ex_icode = ei; ex_dstM = edm; ex_cnd = cnd; w_icode = wi;
    push_exp(tag, ctl, run, hlt, c, s, b);
    @(negedge clk);
    check_now();
  endtask

  task automatic idle_cyc(input string tag, input logic st, input logic [5:0] ctl,
                          input logic run, input logic hlt, input logic [31:0] c,
                          input logic [31:0] s, input logic [31:0] b);
    cyc(tag, st, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, 8'h01, ctl, run, hlt, c, s, b);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0;
    d_icode = 8'h01; d_srcA = 8'h0F; d_srcB = 8'h0F;
    ex_icode = 8'h01; ex_dstM = 8'h0F; ex_cnd = 1'b0; w_icode = 8'h01;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // IDLE with no start: everything frozen, counters at zero.
    for (int i = 0; i < 10; i++)
      idle_cyc("idle", 1'b0, C_CTL_IDLE, 1'b0, 1'b0, 0, 0, 0);

    idle_cyc("start",   1'b1, C_CTL_IDLE, 1'b0, 1'b0, 0, 0, 0);
    idle_cyc("run0",    1'b0, C_CTL_NONE, 1'b1, 1'b0, 0, 0, 0);
    // Load/use via srcA (MRMOVL) then via srcB (POPL).
    cyc("lu_a", 0, 8'h01, 8'h03, 8'h0F, 8'h05, 8'h03, 0, 8'h01, C_CTL_LU,   1, 0, 1, 0, 0);
    cyc("lu_b", 0, 8'h01, 8'h0F, 8'h04, 8'h0B, 8'h04, 0, 8'h01, C_CTL_LU,   1, 0, 2, 1, 1);
    // dstM none never matches, even against a none source.
    cyc("lu_no", 0, 8'h01, 8'h0F, 8'h0F, 8'h05, 8'h0F, 0, 8'h01, C_CTL_NONE, 1, 0, 3, 2, 2);
    // Ret: three bubble cycles after the cycle it sits in decode.
    cyc("ret",  0, 8'h09, 8'h0F, 8'h0F, 8'h01, 8'h0F, 0, 8'h01, C_CTL_NONE, 1, 0, 4, 2, 2);
    idle_cyc("ret_b1", 1'b0, C_CTL_RET,  1'b1, 1'b0, 5, 2, 2);
    idle_cyc("ret_b2", 1'b0, C_CTL_RET,  1'b1, 1'b0, 6, 2, 3);
    idle_cyc("ret_b3", 1'b0, C_CTL_RET,  1'b1, 1'b0, 7, 2, 4);
    idle_cyc("ret_end", 1'b0, C_CTL_NONE, 1'b1, 1'b0, 8, 2, 5);
    // Mispredict then correctly predicted branch.
    cyc("mis",  0, 8'h01, 8'h0F, 8'h0F, 8'h07, 8'h0F, 0, 8'h01, C_CTL_MIS,  1, 0, 9, 2, 5);
    cyc("taken", 0, 8'h01, 8'h0F, 8'h0F, 8'h07, 8'h0F, 1, 8'h01, C_CTL_NONE, 1, 0, 10, 2, 6);
    // Ret in flight squashed by a mispredict.
    cyc("ret2", 0, 8'h09, 8'h0F, 8'h0F, 8'h01, 8'h0F, 0, 8'h01, C_CTL_NONE, 1, 0, 11, 2, 6);
    idle_cyc("ret2_b1", 1'b0, C_CTL_RET, 1'b1, 1'b0, 12, 2, 6);
    cyc("ret_mis", 0, 8'h01, 8'h0F, 8'h0F, 8'h07, 8'h0F, 0, 8'h01, C_CTL_RMIS, 1, 0, 13, 2, 7);
    idle_cyc("squash", 1'b0, C_CTL_NONE, 1'b1, 1'b0, 14, 2, 8);
    // HALT reaches writeback; counters freeze and start is ignored.
    cyc("halt", 0, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 0, 8'h00, C_CTL_NONE, 1, 0, 15, 2, 8);
    idle_cyc("halted",  1'b0, C_CTL_IDLE, 1'b0, 1'b1, 16, 2, 8);
    idle_cyc("h_start", 1'b1, C_CTL_IDLE, 1'b0, 1'b1, 16, 2, 8);
    idle_cyc("h_hold",  1'b0, C_CTL_IDLE, 1'b0, 1'b1, 16, 2, 8);

    // Async reset in the middle of a ret sequence.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    idle_cyc("r_start", 1'b1, C_CTL_IDLE, 1'b0, 1'b0, 0, 0, 0);
    idle_cyc("r_run",   1'b0, C_CTL_NONE, 1'b1, 1'b0, 0, 0, 0);
    cyc("r_ret", 0, 8'h09, 8'h0F, 8'h0F, 8'h01, 8'h0F, 0, 8'h01, C_CTL_NONE, 1, 0, 1, 0, 0);
    idle_cyc("r_b1", 1'b0, C_CTL_RET, 1'b1, 1'b0, 2, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    push_exp("rst_mid", C_CTL_IDLE, 1'b0, 1'b0, 0, 0, 0);
    check_now();
    @(negedge clk);
    rst = 1'b0;
    idle_cyc("post_rst", 1'b0, C_CTL_IDLE, 1'b0, 1'b0, 0, 0, 0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
